// File: rtl/serial_magcmp_pkg.sv
// Shared types and defaults for the serial magnitude comparator.
package serial_magcmp_pkg;

  localparam int DEF_WIDTH = 128;
  localparam int DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE,
    EXTEND,
    SCAN,
    DONE
  } state_t;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic err;
  } cmp_result_t;

endpackage

// File: rtl/serial_magcmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice of each operand.
module magcmp_chunk
  import serial_magcmp_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             gt
);

  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/serial_magcmp.sv
// Multi-cycle magnitude comparator: extends both operands to a common width,
// folds signed order onto unsigned order, then scans CHUNK bits per cycle
// from the MSB end and stops at the first differing chunk.
module serial_magcmp
  import serial_magcmp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [LW-1:0]    a_len,
  input  logic [LW-1:0]    b_len,
  input  logic             a_signed,
  input  logic             b_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic             err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t         state, nextState;
  logic [WIDTH-1:0] aReg, bReg;
  logic [LW-1:0]  aLenReg, bLenReg;
  logic           aSgnReg, bSgnReg;
  logic [IW-1:0]  idx;
  cmp_result_t    res;

  logic           lenBad;
  logic [LW-1:0]  mLen;
  logic           sMode;
  logic [WIDTH-1:0] aExt, bExt;
  logic [IW-1:0]  startIdx;
  logic [CHUNK-1:0] aChunk, bChunk;
  logic           chunkLt, chunkGt;

  // Mask with the low 'len' bits set; len == WIDTH yields all ones.
  function automatic logic [WIDTH-1:0] lowMask(input logic [LW-1:0] len);
    logic [WIDTH:0] t;
    t = ((WIDTH + 1)'(1) << len) - (WIDTH + 1)'(1);
    return t[WIDTH-1:0];
  endfunction

  // Mask the operand to its own length, extend it to m bits and, for a signed
  // compare, flip bit m-1 so that unsigned order matches signed order.
  function automatic logic [WIDTH-1:0] extendOp(input logic [WIDTH-1:0] op,
                                                input logic [LW-1:0]    len,
                                                input logic [LW-1:0]    m,
                                                input logic             s);
    logic [WIDTH-1:0] lenM, mM, v;
    logic             signBit;
    lenM    = lowMask(len);
    mM      = lowMask(m);
    v       = op & lenM;
    signBit = |(v & ~(lenM >> 1));
    if (s && signBit) v = v | (mM & ~lenM);
    if (s) v = v ^ (mM & ~(mM >> 1));
    return v;
  endfunction

  // Extension datapath evaluated from the captured operands during EXTEND.
  always_comb begin
    lenBad   = (aLenReg == '0) || (bLenReg == '0) ||
               (aLenReg > LW'(WIDTH)) || (bLenReg > LW'(WIDTH));
    mLen     = (aLenReg > bLenReg) ? aLenReg : bLenReg;
    sMode    = aSgnReg & bSgnReg;
    aExt     = extendOp(aReg, aLenReg, mLen, sMode);
    bExt     = extendOp(bReg, bLenReg, mLen, sMode);
    startIdx = IW'((int'(mLen) - 1) / CHUNK);
    aChunk   = aReg[int'(idx)*CHUNK +: CHUNK];
    bChunk   = bReg[int'(idx)*CHUNK +: CHUNK];
  end

  magcmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (aChunk),
    .b  (bChunk),
    .lt (chunkLt),
    .gt (chunkGt)
  );

  // State register; reset returns to IDLE from any state.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic for the accept / extend / scan / handshake sequence.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid) nextState = EXTEND;
      EXTEND:  nextState = lenBad ? DONE : SCAN;
      SCAN:    if (chunkLt || chunkGt || (idx == '0)) nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Working registers: operand capture, extension, chunk index and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      aReg    <= '0;
      bReg    <= '0;
      aLenReg <= '0;
      bLenReg <= '0;
      aSgnReg <= 1'b0;
      bSgnReg <= 1'b0;
      idx     <= '0;
      res     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            aReg    <= a;
            bReg    <= b;
            aLenReg <= a_len;
            bLenReg <= b_len;
            aSgnReg <= a_signed;
            bSgnReg <= b_signed;
            res     <= '0;
          end
        end
        EXTEND: begin
          if (lenBad) begin
            res <= '{lt: 1'b0, gt: 1'b0, eq: 1'b0, err: 1'b1};
          end else begin
            aReg <= aExt;
            bReg <= bExt;
            idx  <= startIdx;
          end
        end
        SCAN: begin
          if (chunkLt)          res.lt <= 1'b1;
          else if (chunkGt)     res.gt <= 1'b1;
          else if (idx == '0)   res.eq <= 1'b1;
          else                  idx    <= idx - 1'b1;
        end
        DONE: begin
          if (out_ready) res <= '0;
        end
        default: res <= '0;
      endcase
    end
  end

  // Handshake outputs; flags are only exposed while a result is presented.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    if (state == DONE) {lt, gt, eq, err} = res;
    else               {lt, gt, eq, err} = 4'b0000;
  end

endmodule

// File: doc/serial_magcmp.md
# serial_magcmp

Multi-cycle magnitude comparator that takes two mixed-width, mixed-signedness operands of up to 128 bits and returns less-than, greater-than and equal flags. It applies Verilog relational semantics: if both operands are signed the compare is signed, otherwise it is unsigned, and both operands are extended to the wider of the two widths. It scans CHUNK bits per cycle, starting at the MSB, and stops at the first chunk that differs. It sits behind the SV cosim harness as the sequential counterpart of the combinational relational-operator checks, and drives its result through a valid/ready handshake.

## Interface
- WIDTH, 128, maximum operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, number of bits compared per SCAN cycle.
- LW, $clog2(WIDTH+1), width of the length fields.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set is valid.
- in_ready  output  1  block can accept an operand set; high only in IDLE.
- a, b  input  WIDTH each  operands; only bits [len-1:0] are meaningful.
- a_len, b_len  input  LW each  operand widths; legal range is 1..WIDTH.
- a_signed, b_signed  input  1 each  operand signedness.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- lt, gt, eq, err  output  1 each  result flags.

## Operation
- **Reset:** state=IDLE, in_ready=1, out_valid=0, lt=gt=eq=err=0. All working registers are cleared.
- **IDLE:**
  - When in_valid && in_ready, capture a, b, the lengths and the sign flags, then go to EXTEND.
- **EXTEND** (1 cycle):
  - Illegal length (a_len or b_len equal to 0 or greater than WIDTH): set err=1, lt=gt=eq=0, go to DONE.
  - Otherwise compute M=max(a_len,b_len) and S=a_signed&&b_signed.
  - Mask each operand to its own length.
  - Extend each operand to M bits: sign-extend if S, zero-extend if not. All bits at or above M are 0.
  - If S, invert bit M-1 of both extended operands. This maps signed order onto unsigned order.
  - Set the chunk index to (M-1)/CHUNK, go to SCAN.
- **SCAN** (one chunk per cycle, descending index):
  - Compare chunk[idx] of A against chunk[idx] of B, unsigned.
  - If the chunks differ: latch lt or gt, go to DONE.
  - If they are equal and idx==0: latch eq=1, go to DONE.
  - Otherwise decrement idx.
- **DONE:**
  - out_valid=1. The flags hold stable while out_valid && !out_ready.
  - On out_ready: go to IDLE, and out_valid and all flags clear the following cycle.
- **Invariants:** exactly one of lt/gt/eq/err is 1 whenever out_valid=1. out_valid=0 implies all flags are 0.
- **Mixed signedness:** one signed operand with one unsigned operand gives an unsigned compare, and the signed operand is zero-extended.

## Timing
- An accept edge at T places EXTEND in cycle T+1 and the first SCAN in cycle T+2.
- With N chunks scanned, out_valid first rises 2+N cycles after the accept edge. N is in 1..WIDTH/CHUNK; the err path has N=0.
- Worst case is equal 128-bit operands: N=16, latency 18.
- Throughput: at least one IDLE cycle separates results. in_ready=0 from T+1 until the cycle after the output handshake.
- rst in any state aborts the operation:
  - next cycle is IDLE, out_valid=0, no result is emitted;
  - rst outranks a simultaneous in_valid or out_ready.
- in_valid is ignored outside IDLE, and a, b, a_len, b_len, a_signed, b_signed are sampled only on the accept edge.

## Structure
- Package serial_magcmp_pkg holds:
  - the state enum {IDLE, EXTEND, SCAN, DONE};
  - the defaults for CHUNK and WIDTH;
  - a packed struct cmp_result_t {lt, gt, eq, err}.
- Sub-module magcmp_chunk: a combinational CHUNK-bit unsigned compare producing lt and gt. It is instantiated once and muxed by idx.

## Test plan
- Unsigned: a=9'h1FF (len 9), b=9'h000 (len 9) -> gt=1. Start idx=1, N=1, out_valid at accept+3.
- Signed: a=4'b1000 (-8, len 4), b=6'b000011 (3, len 6), both signed -> lt=1, N=1.
- Mixed: a=4'b1111 signed, b=6'd3 unsigned -> unsigned compare 15 vs 3 -> gt=1.
- Equal: a=b=all ones, len 128, both unsigned -> eq=1, N=16, out_valid at accept+18. Repeat with differing bit 0 -> lt or gt at accept+18.
- Illegal length: a_len=0 -> err=1, lt=gt=eq=0, out_valid at accept+2.
- Hold, then abort:
  - With out_ready held low for 5 cycles, the flags stay stable.
  - A separate run asserts rst in the third SCAN cycle of an equal-operand compare: out_valid never rises and in_ready=1 the next cycle.
